// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: per-source result FIFOs feeding NUM_WB registered write ports
// Optional stall counters are compiled in with WB_ARB_STATS_EN.
module wb_arbiter #(
    parameter int WORD_SIZE     = 64,
    parameter int NUM_PHYS_REGS = 128,
    parameter int NUM_SRC       = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int NUM_WB        = 2,
    localparam int PW           = $clog2(NUM_PHYS_REGS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC-1:0][PW-1:0]          src_index,
    input  logic [NUM_SRC-1:0][WORD_SIZE-1:0]   src_data,
    output logic [NUM_WB-1:0]                   wb_en,
    output logic [NUM_WB-1:0][PW-1:0]           wb_index,
    output logic [NUM_WB-1:0][WORD_SIZE-1:0]    wb_data,
`ifdef WB_ARB_STATS_EN
    output logic [NUM_SRC-1:0][31:0]            stall_cnt,
`endif
    output logic                                busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [AW:0]            r_wptr    [NUM_SRC];
    logic [AW:0]            r_rptr    [NUM_SRC];
    logic [PW-1:0]          r_mem_idx [NUM_SRC][FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   r_mem_dat [NUM_SRC][FIFO_DEPTH];
    logic [SW-1:0]          r_rr;
    logic                   r_live;
    logic [NUM_WB-1:0]                  r_wb_en;
    logic [NUM_WB-1:0][PW-1:0]          r_wb_idx;
    logic [NUM_WB-1:0][WORD_SIZE-1:0]   r_wb_dat;

    logic [NUM_SRC-1:0]     w_empty;
    logic [NUM_SRC-1:0]     w_full;
    logic [NUM_SRC-1:0]     w_push;
    logic [NUM_SRC-1:0]     w_gnt;
    logic [PW-1:0]          w_head_idx [NUM_SRC];
    logic [WORD_SIZE-1:0]   w_head_dat [NUM_SRC];
    logic [NUM_WB-1:0]      w_sel_vld;
    logic [PW-1:0]          w_sel_idx  [NUM_WB];
    logic [WORD_SIZE-1:0]   w_sel_dat  [NUM_WB];
    logic [SW-1:0]          w_last;
    logic [SW-1:0]          w_s;
    logic                   w_any;
    logic                   w_dup;
    int                     w_cnt;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            w_empty[s]    = (r_wptr[s] == r_rptr[s]);
            w_full[s]     = (r_wptr[s][AW] != r_rptr[s][AW]) &&
                            (r_wptr[s][AW-1:0] == r_rptr[s][AW-1:0]);
            w_head_idx[s] = r_mem_idx[s][r_rptr[s][AW-1:0]];
            w_head_dat[s] = r_mem_dat[s][r_rptr[s][AW-1:0]];
        end
    end

    // Readiness comes only from registered occupancy, so a full FIFO never passes through.
    assign src_ready = r_live ? ~w_full : '0;
    assign w_push    = src_valid & src_ready & {NUM_SRC{~flush}};

    always_comb begin
        w_gnt     = '0;
        w_sel_vld = '0;
        w_last    = r_rr;
        w_s       = r_rr;
        w_any     = 1'b0;
        w_dup     = 1'b0;
        w_cnt     = 0;
        for (int k = 0; k < NUM_WB; k++) begin
            w_sel_idx[k] = '0;
            w_sel_dat[k] = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            w_s   = SW'((int'(r_rr) + i) % NUM_SRC);
            w_dup = 1'b0;
            // A head whose destination matches an earlier grant this cycle waits its turn.
            for (int k = 0; k < NUM_WB; k++) begin
                if (k < w_cnt && w_sel_idx[k] == w_head_idx[w_s]) begin
                    w_dup = 1'b1;
                end
            end
            if (!w_empty[w_s] && w_cnt < NUM_WB && !w_dup) begin
                w_gnt[w_s] = 1'b1;
                for (int k = 0; k < NUM_WB; k++) begin
                    if (k == w_cnt) begin
                        w_sel_vld[k] = 1'b1;
                        w_sel_idx[k] = w_head_idx[w_s];
                        w_sel_dat[k] = w_head_dat[w_s];
                    end
                end
                w_last = w_s;
                w_any  = 1'b1;
                w_cnt  = w_cnt + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live   <= 1'b0;
            r_rr     <= '0;
            r_wb_en  <= '0;
            r_wb_idx <= '0;
            r_wb_dat <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_rr    <= '0;
                r_wb_en <= '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    r_wptr[s] <= '0;
                    r_rptr[s] <= '0;
                end
            end else begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (w_push[s]) r_wptr[s] <= r_wptr[s] + 1'b1;
                    if (w_gnt[s])  r_rptr[s] <= r_rptr[s] + 1'b1;
                end
                for (int k = 0; k < NUM_WB; k++) begin
                    r_wb_en[k] <= w_sel_vld[k];
                    if (w_sel_vld[k]) begin
                        r_wb_idx[k] <= w_sel_idx[k];
                        r_wb_dat[k] <= w_sel_dat[k];
                    end
                end
                if (w_any) r_rr <= SW'((int'(w_last) + 1) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_push[s]) begin
                r_mem_idx[s][r_wptr[s][AW-1:0]] <= src_index[s];
                r_mem_dat[s][r_wptr[s][AW-1:0]] <= src_data[s];
            end
        end
    end

    assign wb_en    = r_wb_en;
    assign wb_index = r_wb_idx;
    assign wb_data  = r_wb_dat;
    assign busy     = (|(~w_empty)) | (|r_wb_en);

`ifdef WB_ARB_STATS_EN
    logic [31:0] r_stall [NUM_SRC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SRC; s++) r_stall[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (src_valid[s] && !src_ready[s] && r_stall[s] != 32'hFFFF_FFFF) begin
                    r_stall[s] <= r_stall[s] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) stall_cnt[s] = r_stall[s];
    end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter between the functional units (ALU, FPU, BRU, LSU) and the physical register file write ports.
- Buffers each unit's completed result in a small per-source FIFO.
- Each cycle, grants up to NUM_WB results round-robin and drives them as registered register-file write ports.
- Lets the units complete freely while the register file takes at most NUM_WB writes per cycle.

Parameters:
- WORD_SIZE, 64, result data width
- NUM_PHYS_REGS, 128, physical register count; PW = $clog2(NUM_PHYS_REGS)
- NUM_SRC, 4, number of result sources; source 0=ALU, 1=FPU, 2=BRU, 3=LSU
- FIFO_DEPTH, 4, entries per source FIFO; power of two, >=2
- NUM_WB, 2, write ports driven per cycle; 1 <= NUM_WB <= NUM_SRC

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all buffered results
- src_valid  in  [NUM_SRC]  result offered by source s
- src_ready  out  [NUM_SRC]  FIFO s can accept
- src_index  in  [NUM_SRC][PW]  destination physical register
- src_data  in  [NUM_SRC][WORD_SIZE]  result value
- wb_en  out  [NUM_WB]  write port k valid this cycle
- wb_index  out  [NUM_WB][PW]  destination register for port k
- wb_data  out  [NUM_WB][WORD_SIZE]  value for port k
- busy  out  1  any FIFO non-empty or any wb_en set

Behaviour:

Reset (rst=0, async):
- Clears all FIFOs and rr_ptr to 0.
- wb_en, wb_index, wb_data = 0; busy = 0.
- src_ready = 0 while rst=0, then 1 from the first cycle after deassertion.

Accept:
- A beat is pushed into FIFO s on a rising edge with src_valid[s] && src_ready[s].
- src_ready[s] = !full[s], from registered occupancy only. A full FIFO stays not-ready even when it pops that cycle (no pass-through).
- src_index/src_data are ignored when src_valid=0.

Grant (combinational from FIFO heads, results registered):
- Scan sources starting at rr_ptr, wrapping modulo NUM_SRC.
- Grant up to NUM_WB non-empty heads in scan order.
- The i-th granted head goes to port i. Unused ports have wb_en=0; wb_index/wb_data hold their previous values.
- Duplicate index: if a head's index equals that of an earlier head granted the same cycle, skip it (it stays queued) and continue the scan.
- Granted entries pop at the edge where wb_* are registered.
- rr_ptr update: (last granted source + 1) mod NUM_SRC; unchanged when nothing is granted.

Latency:
- A beat accepted at edge E can be granted at edge E+1, with wb_en high in the cycle after E+1.
- A beat accepted into a non-empty FIFO waits for every entry ahead of it.
- Order within a source is strictly FIFO. There is no ordering guarantee across sources.

Pointers:
- Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- full = MSBs differ and low bits equal; empty = pointers equal.

Flush:
- At the next edge, empties all FIFOs, clears wb_en, and resets rr_ptr to 0.
- Overrides a push and a grant in the same cycle; the beat offered that cycle is dropped.
- src_ready stays 1 through the flush.

busy: combinational OR of !empty[s] and wb_en[k].

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined:
  - Adds output stall_cnt [NUM_SRC][32]. Counter s increments each cycle src_valid[s] && !src_ready[s] and saturates at 32'hFFFFFFFF.
  - Counters clear on rst only, not on flush.
- When undefined: the port and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then ALU pushes idx 5 / data 0xAB at edge E -> wb_en[0]=1, wb_index[0]=5, wb_data[0]=0xAB in the cycle after E+1; wb_en[1]=0; then busy=0.
- All 4 sources push one beat each in the same cycle, rr_ptr=0 -> first grant cycle: ports carry sources 0 and 1; next cycle: sources 2 and 3; rr_ptr ends at 0.
- ALU and FPU heads both target idx 7 -> only the ALU result is written that cycle; FPU idx 7 is written the following cycle.
- LSU holds src_valid with 4 beats while grants are blocked by other traffic -> src_ready[3]=0 when full; no beat lost or reordered; with stats enabled, stall_cnt[3] equals the stalled cycle count.
- Fill FIFOs with 3 beats, assert flush for 1 cycle -> next cycle wb_en=0, busy=0; a later push is written with 2-cycle latency.
- Assert rst low mid-stream with full FIFOs -> outputs 0 immediately (async); no writes appear after reset release.
